// File: rtl/user_popcnt_feeder_pkg.sv
// user_popcnt_feeder_pkg: shared types and constants for the popcount feeder.
// Rev 1.0
`default_nettype none

package user_popcnt_feeder_pkg;

   typedef struct packed {
      int unsigned AddrWidth;
      int unsigned DataWidth;
      int unsigned IdWidth;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [0:0]  aid;
   } obi_a_chan_t;

   typedef struct packed {
      obi_a_chan_t a;
      logic        req;
   } obi_default_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
   } obi_r_chan_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      obi_r_chan_t r;
   } obi_default_rsp_t;

   typedef enum logic [2:0] {
      FsmIdle   = 3'd0,
      FsmClrReq = 3'd1,
      FsmClrRsp = 3'd2,
      FsmAddReq = 3'd3,
      FsmAddRsp = 3'd4,
      FsmRdReq  = 3'd5,
      FsmRdRsp  = 3'd6
   } fsm_state_e;

   // Register indices as seen on addr[4:2]
   localparam logic [2:0] REG_PUSH   = 3'd0;
   localparam logic [2:0] REG_CTRL   = 3'd1;
   localparam logic [2:0] REG_STATUS = 3'd2;
   localparam logic [2:0] REG_RESULT = 3'd3;
   localparam logic [2:0] REG_ERRCNT = 3'd4;

   localparam logic [31:0] ACC_CLR = 32'h0;
   localparam logic [31:0] ACC_ADD = 32'h4;
   localparam logic [31:0] ACC_RD  = 32'h8;

   localparam int unsigned STAT_ERR_BIT  = 8;
   localparam int unsigned STAT_RV_BIT   = 7;
   localparam int unsigned STAT_BUSY_BIT = 6;
   localparam int unsigned STAT_CNT_W    = 6;

endpackage

`default_nettype wire

// File: rtl/user_popcnt_feeder_fifo.sv
// user_popcnt_feeder_fifo: small synchronous FIFO holding words queued for the accumulator.
// Rev 1.0
`default_nettype none

module user_popcnt_feeder_fifo #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned FifoDepth = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [DataWidth-1:0]         data_i,
   input  logic                         pop_i,
   output logic [DataWidth-1:0]         data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(FifoDepth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(FifoDepth);

   logic [DataWidth-1:0] mem_q [FifoDepth];
   logic [PtrW-1:0]      wptr_q;
   logic [PtrW-1:0]      rptr_q;
   logic [PtrW:0]        cnt_q;
   logic                 push_ok;
   logic                 pop_ok;

   assign full_o  = (cnt_q == (PtrW+1)'(FifoDepth));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < FifoDepth; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop_ok) begin
            rptr_q <= rptr_q + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (pop_ok && !push_ok) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/user_popcnt_feeder.sv
// user_popcnt_feeder: OBI front-end that batches FIFO words into clear/add/read accesses
// on the downstream set-bit accumulator. Option: USER_POPCNT_FEEDER_ERR_CNT_EN. Rev 1.0
`default_nettype none

module user_popcnt_feeder
   import user_popcnt_feeder_pkg::*;
#(
   parameter obi_cfg_t    ObiCfg     = ObiDefaultConfig,
   parameter type         obi_req_t  = obi_default_req_t,
   parameter type         obi_rsp_t  = obi_default_rsp_t,
   parameter int unsigned FifoDepth  = 4,
   parameter logic [31:0] TargetBase = 32'h2000_1000
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  obi_req_t sbr_obi_req_i,
   output obi_rsp_t sbr_obi_rsp_o,
   output obi_req_t mgr_obi_req_o,
   input  obi_rsp_t mgr_obi_rsp_i
);

   localparam int unsigned DataWidth = ObiCfg.DataWidth;

   fsm_state_e state_q, state_d;

   logic                        fifo_push;
   logic                        fifo_pop;
   logic [DataWidth-1:0]        fifo_head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FifoDepth):0]  fifo_count;

   logic                        idle;
   logic                        start_en;
   logic                        mgr_err;
   logic [31:0]                 status;
   logic [31:0]                 rdata_d;
   logic                        rerr_d;

   logic                        rvalid_q;
   logic [ObiCfg.IdWidth-1:0]   rid_q;
   logic [31:0]                 rdata_q;
   logic                        rerr_q;
   logic [31:0]                 result_q;
   logic                        result_valid_q;
   logic                        err_q;
   logic                        unused_bits;

   assign idle    = (state_q == FsmIdle);
   assign mgr_err = mgr_obi_rsp_i.rvalid && mgr_obi_rsp_i.r.err;

   assign unused_bits = ^{sbr_obi_req_i.a.addr[31:5], sbr_obi_req_i.a.addr[1:0],
                          sbr_obi_req_i.a.be, mgr_obi_rsp_i.r.rid};

   user_popcnt_feeder_fifo #(
      .DataWidth (DataWidth),
      .FifoDepth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (sbr_obi_req_i.a.wdata),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifdef USER_POPCNT_FEEDER_ERR_CNT_EN
   logic        errcnt_clr;
   logic [15:0] errcnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         errcnt_q <= '0;
      end else if (errcnt_clr) begin
         errcnt_q <= '0;
      end else if (mgr_err && (errcnt_q != 16'hFFFF)) begin
         errcnt_q <= errcnt_q + 16'd1;
      end
   end
`endif

   always_comb begin
      status                                = '0;
      status[STAT_ERR_BIT]                  = err_q;
      status[STAT_RV_BIT]                   = result_valid_q;
      status[STAT_BUSY_BIT]                 = !idle;
      status[STAT_CNT_W-1:0]                = STAT_CNT_W'(fifo_count);
   end

   // Side effects and read data are decided in the request cycle; the
   // response is the registered copy, so it reflects pre-update state.
   always_comb begin
      rdata_d   = '0;
      rerr_d    = 1'b0;
      fifo_push = 1'b0;
      start_en  = 1'b0;
`ifdef USER_POPCNT_FEEDER_ERR_CNT_EN
      errcnt_clr = 1'b0;
`endif
      if (sbr_obi_req_i.req) begin
         case (sbr_obi_req_i.a.addr[4:2])
            REG_PUSH: begin
               if (sbr_obi_req_i.a.we && !fifo_full && idle) begin
                  fifo_push = 1'b1;
               end else begin
                  rerr_d = 1'b1;
               end
            end
            REG_CTRL: begin
               if (sbr_obi_req_i.a.we) begin
                  start_en = sbr_obi_req_i.a.wdata[0] && idle;
               end else begin
                  rerr_d = 1'b1;
               end
            end
            REG_STATUS: begin
               if (sbr_obi_req_i.a.we) rerr_d = 1'b1;
               else                    rdata_d = status;
            end
            REG_RESULT: begin
               if (sbr_obi_req_i.a.we) rerr_d = 1'b1;
               else                    rdata_d = result_q;
            end
`ifdef USER_POPCNT_FEEDER_ERR_CNT_EN
            REG_ERRCNT: begin
               if (sbr_obi_req_i.a.we) errcnt_clr = 1'b1;
               else                    rdata_d = {16'h0000, errcnt_q};
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rid_q    <= '0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
      end else begin
         rvalid_q <= sbr_obi_req_i.req;
         if (sbr_obi_req_i.req) begin
            rid_q   <= sbr_obi_req_i.a.aid;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
         end
      end
   end

   always_comb begin
      sbr_obi_rsp_o          = '0;
      sbr_obi_rsp_o.gnt      = sbr_obi_req_i.req;
      sbr_obi_rsp_o.rvalid   = rvalid_q;
      sbr_obi_rsp_o.r.rdata  = rdata_q;
      sbr_obi_rsp_o.r.rid    = rid_q;
      sbr_obi_rsp_o.r.err    = rerr_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FsmIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d              = state_q;
      fifo_pop             = 1'b0;
      mgr_obi_req_o        = '0;
      mgr_obi_req_o.a.be   = 4'hF;
      case (state_q)
         FsmIdle: begin
            if (start_en) state_d = FsmClrReq;
         end
         FsmClrReq: begin
            mgr_obi_req_o.req    = 1'b1;
            mgr_obi_req_o.a.we   = 1'b1;
            mgr_obi_req_o.a.addr = TargetBase + ACC_CLR;
            if (mgr_obi_rsp_i.gnt) state_d = FsmClrRsp;
         end
         FsmClrRsp, FsmAddRsp: begin
            if (mgr_obi_rsp_i.rvalid) state_d = fifo_empty ? FsmRdReq : FsmAddReq;
         end
         FsmAddReq: begin
            mgr_obi_req_o.req     = 1'b1;
            mgr_obi_req_o.a.we    = 1'b1;
            mgr_obi_req_o.a.addr  = TargetBase + ACC_ADD;
            mgr_obi_req_o.a.wdata = fifo_head;
            if (mgr_obi_rsp_i.gnt) begin
               fifo_pop = 1'b1;
               state_d  = FsmAddRsp;
            end
         end
         FsmRdReq: begin
            mgr_obi_req_o.req    = 1'b1;
            mgr_obi_req_o.a.addr = TargetBase + ACC_RD;
            if (mgr_obi_rsp_i.gnt) state_d = FsmRdRsp;
         end
         FsmRdRsp: begin
            if (mgr_obi_rsp_i.rvalid) state_d = FsmIdle;
         end
         default: state_d = FsmIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         if (start_en) begin
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
         end
         if (mgr_err) begin
            err_q <= 1'b1;
         end
         if ((state_q == FsmRdRsp) && mgr_obi_rsp_i.rvalid) begin
            result_q       <= mgr_obi_rsp_i.r.rdata;
            result_valid_q <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_user_popcnt_feeder.sv
// tb_user_popcnt_feeder: directed bench with an accumulator model on the manager port.
// Rev 1.0
`default_nettype none

module tb_user_popcnt_feeder;
   import user_popcnt_feeder_pkg::*;

   localparam logic [31:0] TB_BASE = 32'h2000_1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   obi_default_req_t sbr_req;
   obi_default_rsp_t sbr_rsp;
   obi_default_req_t mgr_req;
   obi_default_rsp_t mgr_rsp;
   logic             mgr_gnt;

   int total = 0;
   int bad   = 0;

   // Expected manager transactions of the current batch, written by the stimulus
   logic        exp_we    [16];
   logic [31:0] exp_addr  [16];
   logic [31:0] exp_wdata [16];
   int          exp_n     = 0;
   int          batch_cnt = 0;
   int          seen_batch = 0;
   int          hs_idx    = 0;
   logic [31:0] sw_q [$];
   logic [31:0] exp_result = 0;

   // Downstream accumulator model state
   logic        stall_2nd  = 1'b0;
   logic        err_on_clr = 1'b0;
   logic [31:0] acc = 0;
   int          wait_cnt = 0;
   int          adds_seen = 0;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_data;

   always #5 clk = ~clk;

   user_popcnt_feeder #(
      .ObiCfg     (ObiDefaultConfig),
      .obi_req_t  (obi_default_req_t),
      .obi_rsp_t  (obi_default_rsp_t),
      .FifoDepth  (4),
      .TargetBase (TB_BASE)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .sbr_obi_req_i (sbr_req),
      .sbr_obi_rsp_o (sbr_rsp),
      .mgr_obi_req_o (mgr_req),
      .mgr_obi_rsp_i (mgr_rsp)
   );

   assign mgr_gnt = mgr_req.req &&
                    !(stall_2nd && (adds_seen == 1) && (mgr_req.a.addr == TB_BASE + 32'h4) && (wait_cnt < 3));

   always_comb begin
      mgr_rsp          = '0;
      mgr_rsp.gnt      = mgr_gnt;
      mgr_rsp.rvalid   = rsp_valid;
      mgr_rsp.r.rdata  = rsp_data;
      mgr_rsp.r.err    = rsp_err;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         acc       <= '0;
         wait_cnt  <= 0;
         adds_seen <= 0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         if (mgr_req.req && !mgr_gnt) wait_cnt <= wait_cnt + 1;
         if (mgr_req.req && mgr_gnt) begin
            wait_cnt  <= 0;
            rsp_valid <= 1'b1;
            if (mgr_req.a.addr == TB_BASE) begin
               acc       <= '0;
               adds_seen <= 0;
               rsp_err   <= err_on_clr;
            end else if (mgr_req.a.addr == TB_BASE + 32'h4) begin
               acc       <= acc + $countones(mgr_req.a.wdata);
               adds_seen <= adds_seen + 1;
            end else if (mgr_req.a.addr == TB_BASE + 32'h8) begin
               rsp_data  <= acc;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   logic        prev_wait = 1'b0;
   logic [31:0] prev_addr, prev_wdata;
   logic        prev_we;

   always @(negedge clk) begin
      if (rst) begin
         prev_wait = 1'b0;
      end else begin
         if (prev_wait) begin
            chk("mgr_req_held", {31'b0, mgr_req.req}, 32'd1);
            chk("mgr_addr_stable", mgr_req.a.addr, prev_addr);
            chk("mgr_wdata_stable", mgr_req.a.wdata, prev_wdata);
            chk("mgr_we_stable", {31'b0, mgr_req.a.we}, {31'b0, prev_we});
         end
         if (mgr_req.req) begin
            chk("mgr_be", {28'b0, mgr_req.a.be}, 32'hF);
            chk("mgr_aid", {31'b0, mgr_req.a.aid}, 32'd0);
            if (mgr_gnt) begin
               if (seen_batch != batch_cnt) begin
                  seen_batch = batch_cnt;
                  hs_idx     = 0;
               end
               if (hs_idx >= exp_n) begin
                  total++;
                  bad++;
                  $display("FAIL mgr_spurious: got addr %h, required no transaction", mgr_req.a.addr);
               end else begin
                  chk("mgr_we", {31'b0, mgr_req.a.we}, {31'b0, exp_we[hs_idx]});
                  chk("mgr_addr", mgr_req.a.addr, exp_addr[hs_idx]);
                  if (exp_we[hs_idx]) chk("mgr_wdata", mgr_req.a.wdata, exp_wdata[hs_idx]);
               end
               hs_idx++;
            end
            prev_wait  = !mgr_gnt;
            prev_addr  = mgr_req.a.addr;
            prev_wdata = mgr_req.a.wdata;
            prev_we    = mgr_req.a.we;
         end else begin
            prev_wait = 1'b0;
         end
      end
   end

   task automatic cpu(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
      @(negedge clk);
      sbr_req         = '0;
      sbr_req.req     = 1'b1;
      sbr_req.a.we    = we;
      sbr_req.a.addr  = addr;
      sbr_req.a.wdata = wdata;
      sbr_req.a.be    = 4'hF;
      sbr_req.a.aid   = 1'b1;
      #1;
      chk("sbr_gnt", {31'b0, sbr_rsp.gnt}, 32'd1);
      @(negedge clk);
      sbr_req.req = 1'b0;
      chk("sbr_rvalid", {31'b0, sbr_rsp.rvalid}, 32'd1);
      chk("sbr_rid", {31'b0, sbr_rsp.r.rid}, 32'd1);
      rdata = sbr_rsp.r.rdata;
      err   = sbr_rsp.r.err;
   endtask

   task automatic push(input logic [31:0] w, input logic exp_err);
      logic [31:0] rd;
      logic        er;
      cpu(1'b1, 32'h0, w, rd, er);
      chk("push_err", {31'b0, er}, {31'b0, exp_err});
      if (!exp_err) sw_q.push_back(w);
   endtask

   task automatic start(input logic accept);
      logic [31:0] rd;
      logic        er;
      if (accept) begin
         exp_n = 0;
         exp_result = 0;
         exp_we[0] = 1'b1; exp_addr[0] = TB_BASE; exp_wdata[0] = 32'h0;
         exp_n = 1;
         foreach (sw_q[i]) begin
            exp_we[exp_n]    = 1'b1;
            exp_addr[exp_n]  = TB_BASE + 32'h4;
            exp_wdata[exp_n] = sw_q[i];
            exp_result       = exp_result + $countones(sw_q[i]);
            exp_n++;
         end
         exp_we[exp_n] = 1'b0; exp_addr[exp_n] = TB_BASE + 32'h8; exp_wdata[exp_n] = 32'h0;
         exp_n++;
         sw_q.delete();
         batch_cnt++;
      end
      cpu(1'b1, 32'h4, 32'h1, rd, er);
      chk("start_err", {31'b0, er}, 32'd0);
   endtask

   task automatic wait_idle();
      logic [31:0] rd;
      logic        er;
      logic        done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         cpu(1'b0, 32'h8, 32'h0, rd, er);
         if (!rd[6]) done = 1'b1;
      end
      chk("idle_reached", {31'b0, done}, 32'd1);
      chk("mgr_txn_count", hs_idx, exp_n);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] addr,
                         input logic [31:0] exp_d, input logic exp_e);
      logic [31:0] rd;
      logic        er;
      cpu(1'b0, addr, 32'h0, rd, er);
      chk(name, rd, exp_d);
      chk({name, "_err"}, {31'b0, er}, {31'b0, exp_e});
   endtask

   task automatic wr_chk(input string name, input logic [31:0] addr,
                         input logic [31:0] wd, input logic exp_e);
      logic [31:0] rd;
      logic        er;
      cpu(1'b1, addr, wd, rd, er);
      chk({name, "_err"}, {31'b0, er}, {31'b0, exp_e});
   endtask

   initial begin
      logic found;
      logic [31:0] errcnt_exp;
      sbr_req = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mgr_req", {31'b0, mgr_req.req}, 32'd0);
      chk("rst_mgr_we", {31'b0, mgr_req.a.we}, 32'd0);
      chk("rst_mgr_addr", mgr_req.a.addr, 32'd0);
      chk("rst_mgr_wdata", mgr_req.a.wdata, 32'd0);
      chk("rst_sbr_rvalid", {31'b0, sbr_rsp.rvalid}, 32'd0);
      rst = 1'b0;
      rd_chk("rst_status", 32'h8, 32'h000, 1'b0);
      rd_chk("rst_result", 32'hC, 32'h0, 1'b0);

      // Basic batch
      push(32'hFFFF_FFFF, 1'b0);
      push(32'h0000_000F, 1'b0);
      push(32'h8000_0001, 1'b0);
      rd_chk("status_cnt3", 32'h8, 32'h003, 1'b0);
      start(1'b1);
      wait_idle();
      rd_chk("result_38", 32'hC, 32'd38, 1'b0);
      rd_chk("result_model1", 32'hC, exp_result, 1'b0);
      rd_chk("status_done1", 32'h8, 32'h080, 1'b0);

      // Empty batch: clear then read only
      start(1'b1);
      wait_idle();
      rd_chk("result_empty", 32'hC, 32'h0, 1'b0);
      rd_chk("status_done2", 32'h8, 32'h080, 1'b0);

      // Register decode corners
      rd_chk("rd_push", 32'h0, 32'h0, 1'b1);
      rd_chk("rd_ctrl", 32'h4, 32'h0, 1'b1);
      wr_chk("wr_status", 32'h8, 32'h1FF, 1'b1);
      wr_chk("wr_result", 32'hC, 32'h5, 1'b1);
      rd_chk("rd_unmapped", 32'h14, 32'h0, 1'b0);
      wr_chk("ctrl_nostart", 32'h4, 32'h0, 1'b0);
      rd_chk("status_nostart", 32'h8, 32'h080, 1'b0);

      // Overflow, then a stalled second add with busy-time pushes and STARTs
      push(32'h0000_0001, 1'b0);
      push(32'h0000_0003, 1'b0);
      push(32'h0000_0007, 1'b0);
      push(32'h0000_000F, 1'b0);
      push(32'hFFFF_FFFF, 1'b1);
      rd_chk("status_full", 32'h8, 32'h084, 1'b0);
      stall_2nd = 1'b1;
      start(1'b1);
      push(32'h0000_00FF, 1'b1);
      start(1'b0);
      wait_idle();
      stall_2nd = 1'b0;
      rd_chk("result_10", 32'hC, 32'd10, 1'b0);
      rd_chk("result_model3", 32'hC, exp_result, 1'b0);
      rd_chk("status_done3", 32'h8, 32'h080, 1'b0);

      // Manager error on the clear
      err_on_clr = 1'b1;
      push(32'h0000_0003, 1'b0);
      start(1'b1);
      wait_idle();
      err_on_clr = 1'b0;
      rd_chk("status_err", 32'h8, 32'h180, 1'b0);
      rd_chk("result_err_batch", 32'hC, 32'd2, 1'b0);
`ifdef USER_POPCNT_FEEDER_ERR_CNT_EN
      errcnt_exp = 32'd1;
`else
      errcnt_exp = 32'd0;
`endif
      rd_chk("errcnt", 32'h10, errcnt_exp, 1'b0);
      wr_chk("errcnt_clr", 32'h10, 32'h0, 1'b0);
      rd_chk("errcnt_after_clr", 32'h10, 32'h0, 1'b0);

      // Reset pulse while an add response is outstanding
      push(32'h0000_000F, 1'b0);
      push(32'h0000_00FF, 1'b0);
      start(1'b1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (mgr_req.req && mgr_gnt && (mgr_req.a.addr == TB_BASE + 32'h4)) found = 1'b1;
      end
      chk("add_handshake_seen", {31'b0, found}, 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_req", {31'b0, mgr_req.req}, 32'd0);
      exp_n = 0;
      batch_cnt++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rd_chk("status_after_rst", 32'h8, 32'h000, 1'b0);
      rd_chk("result_after_rst", 32'hC, 32'h0, 1'b0);
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/user_popcnt_feeder.md
Name: user_popcnt_feeder

Overview:
- OBI subordinate front-end plus OBI manager back-end that sits directly upstream of the user-domain set-bit accumulator peripheral.
- Software pushes data words into a small FIFO, then issues one CTRL write.
- The block autonomously drives the accumulator: clear (offset 0x0), one add write per FIFO word (offset 0x4), and a final read (offset 0x8).
- The read result is latched into a local RESULT register, so the CPU needs only one command per batch.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration shared by both ports.
- obi_req_t, logic, OBI request struct type.
- obi_rsp_t, logic, OBI response struct type.
- FifoDepth, 4, number of data FIFO entries; power of two, at least 2.
- TargetBase, 32'h2000_1000, base address of the downstream accumulator peripheral.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- sbr_obi_req_i  in  obi_req_t  CPU-side subordinate request.
- sbr_obi_rsp_o  out  obi_rsp_t  CPU-side subordinate response.
- mgr_obi_req_o  out  obi_req_t  manager request toward the accumulator.
- mgr_obi_rsp_i  in  obi_rsp_t  manager response from the accumulator.

Behaviour:
- Reset: one clock clk_i; reset rst_i is asynchronous, active-high. On reset, all registers clear:
  - FIFO empty, FSM IDLE, RESULT=0, result_valid=0, sticky err=0.
  - sbr rvalid=0; mgr req=0, we=0, addr=0, wdata=0.
- Subordinate timing: gnt = req combinationally. Address, we, wdata and aid are registered. rvalid, rid, rdata and err follow exactly 1 cycle later. Register decode uses addr[4:2].
- 0x00 PUSH, write-only:
  - Enqueues wdata when the FIFO is not full and FSM is IDLE.
  - A push while full or non-IDLE is dropped and answered with err=1.
  - A read returns err=1.
- 0x04 CTRL, write-only:
  - bit0 START: accepted only in IDLE; clears result_valid and err, then enters CLR.
  - START while busy, or any write with bit0=0, is a no-op with err=0.
  - A read returns err=1.
- 0x08 STATUS, read-only:
  - rdata = {err[8], result_valid[7], busy[6], count[5:0]}.
  - busy = FSM != IDLE.
  - A write returns err=1.
- 0x0C RESULT, read-only: returns the latched 32-bit result. A write returns err=1.
- Other offsets: read 0, no error.
- FSM, at most one outstanding manager transaction:
  - IDLE: waits for START.
  - CLR_REQ: req=1, we=1, addr=TargetBase+0x0, wdata=0. On gnt, go to CLR_RSP.
  - CLR_RSP: on rvalid, go to ADD_REQ if the FIFO is non-empty, else RD_REQ.
  - ADD_REQ: req=1, we=1, addr=TargetBase+0x4, wdata=FIFO head. On gnt, pop the FIFO and go to ADD_RSP.
  - ADD_RSP: on rvalid, go to ADD_REQ if the FIFO is non-empty, else RD_REQ.
  - RD_REQ: req=1, we=0, addr=TargetBase+0x8. On gnt, go to RD_RSP.
  - RD_RSP: on rvalid, latch rdata into RESULT, set result_valid=1, go to IDLE.
- Manager request fields are held stable from req assertion until gnt. be is always 4'hF. aid is always 0.
- Manager err: any rvalid with err=1 sets the sticky err bit. The sequence continues unchanged.
- Simultaneous events: a CPU STATUS read in the same cycle the FSM returns to IDLE returns the pre-update values. FIFO count never exceeds FifoDepth.
- Reset mid-sequence: the FSM aborts immediately and mgr req drops asynchronously. The downstream accumulator is not restored.

Optional Feature:
- Macro USER_POPCNT_FEEDER_ERR_CNT_EN.
- When defined: a 16-bit saturating counter of manager err responses, readable at 0x10. A write to 0x10 clears it. It resets to 0 and saturates at 16'hFFFF.
- When undefined: no counter is instantiated, and 0x10 reads 0 with no error.

Decomposition:
- Package user_popcnt_feeder_pkg holds:
  - the FSM state enum;
  - register offset localparams (PUSH, CTRL, STATUS, RESULT, ERRCNT);
  - accumulator offset localparams (CLR=0x0, ADD=0x4, RD=0x8);
  - STATUS bit-position constants.
- Sub-module user_popcnt_feeder_fifo: synchronous FIFO (push/pop/full/empty/count), DataWidth wide, FifoDepth deep, with asynchronous active-high reset.

Test Plan:
- Push 32'hFFFF_FFFF, 32'h0000_000F, 32'h8000_0001, then START; the model accumulator grants immediately -> manager sequence is clear, 3 adds with those wdata, read. The model returns 38 -> RESULT=38, STATUS=0x080 (result_valid=1, busy=0, count=0).
- START with an empty FIFO -> manager issues clear then read only; RESULT latches the model value 0.
- Push 5 words with FifoDepth=4 -> the 5th push gets err=1; STATUS count=4.
- Push during busy, and START during busy -> the push gets err=1 and the FIFO is unchanged; the START is ignored and the sequence is not restarted.
- Model holds gnt low for 3 cycles on the 2nd add -> manager addr/wdata stay stable; pop occurs only on the gnt cycle; RESULT is correct.
- Model returns err=1 on the clear, and rst_i is pulsed mid-ADD_RSP:
  - err=1 -> STATUS bit8=1; with USER_POPCNT_FEEDER_ERR_CNT_EN defined, 0x10 reads 1.
  - rst_i pulse -> mgr req=0 in the same cycle and STATUS reads 0 afterwards.
